note_sequencer: RTL and testbench

Control stage directly upstream of the note datapath: turns debounced front-panel keys into the datapath's load/play strobes. In record mode it emits one write strobe per note keypress and tracks how many of the 16 note slots are filled. In play mode it steps a slot counter through the recorded notes at a fixed tempo, driving the highlight enable and redraw requests for the VGA cell of the current note.

---
 rtl/music_pkg.sv | 27 ++
 rtl/key_edge.sv | 19 +
 rtl/note_sequencer.sv | 148 ++++++++++++++
 tb/tb_note_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the note sequencer control stage.
// Slot geometry, tick widths and the default tempo at a 50 MHz clock.
package music_pkg;

  localparam int NUM_SLOTS        = 16;
  localparam int SLOT_W           = $clog2(NUM_SLOTS);
  localparam int USED_W           = SLOT_W + 1;
  localparam int TICK_W           = 24;
  localparam int DEF_FETCH_CYCLES = 3;
  localparam int DEF_NOTE_TICKS   = 12_500_000;
  localparam int DEF_GAP_TICKS    = 2_500_000;

  typedef enum logic [2:0] {
    IDLE,
    REC_STROBE,
    REC_GAP,
    PLAY_FETCH,
    PLAY_NOTE,
    PLAY_GAP
  } seq_state_e;

  // A state lasting dur cycles loads dur-1 and leaves when the counter reaches 0.
  function automatic logic [TICK_W-1:0] tick_load(input int dur);
    return TICK_W'(dur - 1);
  endfunction

endpackage

// File: rtl/key_edge.sv
// One-cycle rise detect on a debounced key level.
// The rise is combinational from the live key so the FSM samples it on the same edge.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic rise_o
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (!reset) key_q <= 1'b0;
    else        key_q <= key_i;
  end

  assign rise_o = key_i & ~key_q;

endmodule

// File: rtl/note_sequencer.sv
// Record/playback control: note write strobes while recording, and slot
// stepping with highlight/redraw requests at a fixed tempo while playing.
module note_sequencer
  import music_pkg::*;
#(
  parameter int FETCH_CYCLES = DEF_FETCH_CYCLES,
  parameter int NOTE_TICKS   = DEF_NOTE_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_key,
  input  logic              play_key,
  input  logic              stop_key,
  input  logic              loop_en,
  output logic              ld_note,
  output logic              ld_play,
  output logic [SLOT_W-1:0] note_counter,
  output logic              next_note_en,
  output logic              display_note,
  output logic [USED_W-1:0] slots_used,
  output logic              full,
  output logic              record_locked
);

  localparam logic [TICK_W-1:0] FETCH_LOAD = tick_load(FETCH_CYCLES);
  localparam logic [TICK_W-1:0] NOTE_LOAD  = tick_load(NOTE_TICKS);
  localparam logic [TICK_W-1:0] GAP_LOAD   = tick_load(GAP_TICKS);
  localparam logic [USED_W-1:0] USED_MAX   = USED_W'(NUM_SLOTS);

  logic note_rise, play_rise, stop_rise;

  key_edge u_note (.clk(clk), .reset(reset), .key_i(note_key), .rise_o(note_rise));
  key_edge u_play (.clk(clk), .reset(reset), .key_i(play_key), .rise_o(play_rise));
  key_edge u_stop (.clk(clk), .reset(reset), .key_i(stop_key), .rise_o(stop_rise));

  seq_state_e        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SLOT_W-1:0] cnt_q, cnt_d;
  logic [USED_W-1:0] used_q, used_d;
  logic              lock_q, lock_d;
  logic              first_q, first_d;
  logic              last_slot;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      cnt_q   <= '0;
      used_q  <= '0;
      lock_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      used_q  <= used_d;
      lock_q  <= lock_d;
      first_q <= first_d;
    end
  end

  assign last_slot = !(({1'b0, cnt_q} + USED_W'(1)) < used_q);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    lock_d  = lock_q;
    first_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // stop outranks play, play outranks note, even when the winner is a no-op
        if (stop_rise) begin
          state_d = IDLE;
        end else if (play_rise) begin
          if (used_q != '0) begin
            state_d = PLAY_FETCH;
            tick_d  = FETCH_LOAD;
            cnt_d   = '0;
            lock_d  = 1'b1;
          end
        end else if (note_rise && (used_q != USED_MAX) && !lock_q) begin
          state_d = REC_STROBE;
        end
      end
      REC_STROBE: state_d = REC_GAP;
      REC_GAP: begin
        state_d = IDLE;
        if (used_q != USED_MAX) used_d = used_q + USED_W'(1);
      end
      PLAY_FETCH: begin
        if (stop_rise) begin
          state_d = IDLE;
        end else if (tick_q == '0) begin
          state_d = PLAY_NOTE;
          tick_d  = NOTE_LOAD;
          first_d = 1'b1;
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      PLAY_NOTE: begin
        if (stop_rise) begin
          state_d = IDLE;
        end else if (tick_q == '0) begin
          state_d = PLAY_GAP;
          tick_d  = GAP_LOAD;
          first_d = 1'b1;
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      PLAY_GAP: begin
        if (stop_rise) begin
          state_d = IDLE;
        end else if (tick_q == '0) begin
          if (!last_slot) begin
            state_d = PLAY_FETCH;
            tick_d  = FETCH_LOAD;
            cnt_d   = cnt_q + SLOT_W'(1);
          end else if (loop_en) begin
            state_d = PLAY_FETCH;
            tick_d  = FETCH_LOAD;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_note       = (state_q == REC_STROBE);
  assign ld_play       = (state_q == PLAY_FETCH) || (state_q == PLAY_NOTE) || (state_q == PLAY_GAP);
  assign next_note_en  = (state_q == PLAY_NOTE);
  // first_q is only ever set on entry to NOTE or GAP; a stop drops it with the state
  assign display_note  = first_q && ((state_q == PLAY_NOTE) || (state_q == PLAY_GAP));
  assign note_counter  = cnt_q;
  assign slots_used    = used_q;
  assign full          = (used_q == USED_MAX);
  assign record_locked = lock_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized directed bench for note_sequencer; expectations come from
// per-press acceptance rules and closed-form playback timing arithmetic.
module tb_note_sequencer;

  localparam int FC  = 3;
  localparam int NT  = 8;
  localparam int GT  = 2;
  localparam int PER = FC + NT + GT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       note_key = 1'b0, play_key = 1'b0, stop_key = 1'b0, loop_en = 1'b0;
  logic       ld_note, ld_play, next_note_en, display_note, full, record_locked;
  logic [3:0] note_counter;
  logic [4:0] slots_used;

  int ncomp = 0;
  int nfail = 0;
  int m_used = 0;
  int m_cnt = 0;
  bit m_locked = 1'b0;

  note_sequencer #(.FETCH_CYCLES(FC), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .note_key(note_key), .play_key(play_key),
    .stop_key(stop_key), .loop_en(loop_en), .ld_note(ld_note), .ld_play(ld_play),
    .note_counter(note_counter), .next_note_en(next_note_en),
    .display_note(display_note), .slots_used(slots_used), .full(full),
    .record_locked(record_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(int e_ldn, int e_ldp, int e_cnt, int e_nne, int e_disp,
                         int e_used, int e_lock);
    chk("ld_note",       32'(ld_note),       32'(e_ldn));
    chk("ld_play",       32'(ld_play),       32'(e_ldp));
    chk("note_counter",  32'(note_counter),  32'(e_cnt));
    chk("next_note_en",  32'(next_note_en),  32'(e_nne));
    chk("display_note",  32'(display_note),  32'(e_disp));
    chk("slots_used",    32'(slots_used),    32'(e_used));
    chk("full",          32'(full),          32'(e_used == 16));
    chk("record_locked", 32'(record_locked), 32'(e_lock));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; note_key = 1'b0; play_key = 1'b0; stop_key = 1'b0;
    step();
    chk_all(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    m_used = 0; m_cnt = 0; m_locked = 1'b0;
  endtask

  // Hold the note key h samples, release for g; an accepted press strobes
  // on the first sample only and bumps the count two samples later.
  task automatic press(int h, int g);
    bit acc = !m_locked && (m_used < 16);
    note_key = 1'b1;
    for (int j = 0; j < h + g; j++) begin
      step();
      chk("ld_note", 32'(ld_note), 32'(acc && j == 0));
      chk("slots_used", 32'(slots_used), 32'((acc && j >= 2) ? m_used + 1 : m_used));
      if (j == h - 1) note_key = 1'b0;
    end
    if (acc) m_used++;
    step();
    chk_all(0, 0, m_cnt, 0, 0, m_used, m_locked);
  endtask

  // Play for n samples; sample t is taken just after edge k+t, where edge k
  // saw the play rise. stop_s >= 1 raises a stop that edge k+stop_s sees.
  task automatic play(int n, int stop_s, bit noise);
    int nslot = m_used;
    int total = loop_en ? 32'h3fff_ffff : nslot * PER;
    int cnt   = m_cnt;
    play_key = 1'b1;
    for (int t = 0; t < n; t++) begin
      bit active;
      int last, ph;
      step();
      play_key = 1'b0;
      active = (nslot > 0) && (t < total) && (stop_s < 0 || t < stop_s);
      last = t;
      if (last > total - 1) last = total - 1;
      if (stop_s >= 0 && last > stop_s - 1) last = stop_s - 1;
      if (nslot > 0) cnt = (last / PER) % nslot;
      ph = t % PER;
      chk_all(0, active, cnt, active && ph >= FC && ph < FC + NT,
              active && (ph == FC || ph == FC + NT), m_used, m_locked || nslot > 0);
      stop_key = (stop_s >= 0) && (t == stop_s - 1);
      note_key = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    note_key = 1'b0; stop_key = 1'b0;
    m_cnt = cnt;
    if (nslot > 0) m_locked = 1'b1;
  endtask

  initial begin
    int n, s;
    step();
    do_reset();

    // three 5-cycle presses, then a few random ones
    for (int i = 0; i < 3; i++) press(5, 2);
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) press($urandom_range(1, 6), $urandom_range(1, 4));

    // one-shot playback with note-key noise that must be ignored
    loop_en = 1'b0;
    play(m_used * PER + 6, -1, 1'b1);
    press(3, 2);

    // fill past capacity
    do_reset();
    n = $urandom_range(17, 19);
    for (int i = 0; i < n; i++) press($urandom_range(1, 3), $urandom_range(1, 2));

    // looping playback stopped somewhere inside a PLAY_NOTE
    do_reset();
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) press($urandom_range(1, 4), $urandom_range(1, 3));
    loop_en = 1'b1;
    s = PER * $urandom_range(0, m_used + 2) + FC + $urandom_range(0, NT - 1);
    play(s + 6, s, 1'b1);
    press(4, 2);
    loop_en = 1'b0;

    // play with nothing recorded
    do_reset();
    play(12, -1, 1'b0);

    // reset landing in the middle of PLAY_NOTE
    for (int i = 0; i < 3; i++) press(2, 2);
    play(FC + 4, -1, 1'b0);
    do_reset();

    // simultaneous play and stop rises from IDLE
    press(2, 2);
    press(2, 2);
    play_key = 1'b1; stop_key = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      play_key = 1'b0; stop_key = 1'b0;
      chk_all(0, 0, 0, 0, 0, m_used, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
